// File: rtl/pred_sched_if.sv
// pred_sched_if: request and one-hot predicate handshake bundle for pred_sched.
interface pred_sched_if #(
   parameter int PORT_COUNT = 2,
   parameter int REQ_COUNT  = 2
);
   localparam int IDX_WIDTH = PORT_COUNT > 1 ? $clog2(PORT_COUNT) : 1;
   logic [REQ_COUNT*IDX_WIDTH-1:0] s_req_tdata;
   logic [REQ_COUNT-1:0]           s_req_tvalid;
   logic [REQ_COUNT-1:0]           s_req_tready;
   logic [PORT_COUNT-1:0]          m_pred_tdata;
   logic                           m_pred_tvalid;
   logic                           m_pred_tready;
   modport master (
      output s_req_tdata, s_req_tvalid, m_pred_tready,
      input  s_req_tready, m_pred_tdata, m_pred_tvalid
   );
   modport slave (
      input  s_req_tdata, s_req_tvalid, m_pred_tready,
      output s_req_tready, m_pred_tdata, m_pred_tvalid
   );
endinterface

// File: rtl/pred_sched.sv
// pred_sched: round-robin predicate scheduler with credit-based flow control toward a demux.
// Defining PRED_SCHED_STATS_EN adds stat_issued/stat_stall counters.
module pred_sched #(
   parameter  int PORT_COUNT = 2,
   parameter  int REQ_COUNT  = 2,
   parameter  int CREDIT_MAX = 8,
   localparam int IDX_WIDTH  = PORT_COUNT > 1 ? $clog2(PORT_COUNT) : 1,
   localparam int CRED_WIDTH = $clog2(CREDIT_MAX + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pred_sched_if.slave           bus,
   input  logic                  done_pulse,
   output logic [CRED_WIDTH-1:0] credit_avail,
   output logic                  err_idx,
   output logic                  err_credit,
   input  logic                  err_clr
`ifdef PRED_SCHED_STATS_EN
   ,
   output logic [31:0]           stat_issued,
   output logic [31:0]           stat_stall
`endif
);
   localparam int REQ_W = REQ_COUNT > 1 ? $clog2(REQ_COUNT) : 1;
   localparam logic [REQ_W:0]          RC   = (REQ_W + 1)'(REQ_COUNT);
   localparam logic [IDX_WIDTH:0]      PC   = (IDX_WIDTH + 1)'(PORT_COUNT);
   localparam logic [CRED_WIDTH-1:0]   CMAX = CRED_WIDTH'(CREDIT_MAX);

   typedef enum logic [1:0] {IDLE, HOLD, NOCRED} state_t;

   state_t                 state, state_nx;
   logic [CRED_WIDTH-1:0]  credits;
   logic [REQ_W-1:0]       last, gnt;
   logic [REQ_W:0]         cand;
   logic [IDX_WIDTH-1:0]   sel;
   logic                   gnt_any, in_range, accept, issue, bad, hs, cred_zero, cred_full;

   // Walk from farthest to nearest so the requester right after the last grant wins.
   always_comb begin
      gnt     = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int k = REQ_COUNT; k >= 1; k--) begin
         cand = {1'b0, last} + (REQ_W + 1)'(k);
         if (cand >= RC) cand = cand - RC;
         if (bus.s_req_tvalid[cand[REQ_W-1:0]]) begin
            gnt     = cand[REQ_W-1:0];
            gnt_any = 1'b1;
         end
      end
   end

   always_comb begin
      sel = '0;
      for (int r = 0; r < REQ_COUNT; r++)
         if (gnt == REQ_W'(r)) sel = bus.s_req_tdata[r*IDX_WIDTH +: IDX_WIDTH];
   end

   assign cred_zero    = credits == '0;
   assign cred_full    = credits == CMAX;
   assign in_range     = {1'b0, sel} < PC;
   assign accept       = state == IDLE && !cred_zero && gnt_any;
   assign issue        = accept && in_range;
   assign bad          = accept && !in_range;
   assign hs           = state == HOLD && bus.m_pred_tready;
   assign credit_avail = credits;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   always_comb begin
      state_nx = (state == IDLE) ? (issue ? HOLD : IDLE) :
                 (state == HOLD) ? (hs ? (cred_zero ? NOCRED : IDLE) : HOLD) :
                 (cred_zero ? NOCRED : IDLE);
   end

   // Ready is withheld during reset even though the grant logic is combinational.
   always_comb begin
      bus.s_req_tready = (rst_n && accept) ? REQ_COUNT'(1) << gnt : '0;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         credits           <= CMAX;
         last              <= REQ_W'(REQ_COUNT - 1);
         bus.m_pred_tdata  <= '0;
         bus.m_pred_tvalid <= 1'b0;
         err_idx           <= 1'b0;
         err_credit        <= 1'b0;
      end else begin
         if (issue && !done_pulse)                   credits <= credits - CRED_WIDTH'(1);
         else if (done_pulse && !issue && !cred_full) credits <= credits + CRED_WIDTH'(1);
         if (accept) last <= gnt;
         if (issue) begin
            bus.m_pred_tdata  <= PORT_COUNT'(1) << sel;
            bus.m_pred_tvalid <= 1'b1;
         end else if (hs) bus.m_pred_tvalid <= 1'b0;
         err_idx    <= bad | (err_idx & ~err_clr);
         err_credit <= (done_pulse & ~issue & cred_full) | (err_credit & ~err_clr);
      end

`ifdef PRED_SCHED_STATS_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         stat_issued <= '0;
         stat_stall  <= '0;
      end else begin
         stat_issued <= stat_issued + 32'(hs);
         stat_stall  <= stat_stall + 32'(state == NOCRED || (state == HOLD && !bus.m_pred_tready));
      end
`endif
endmodule
